// File: rtl/raster_scan.sv
// Bounding-box rasterizer: latches one triangle descriptor and walks its box in
// raster order, emitting one candidate pixel per cycle over valid/ready.
module raster_scan #(
  parameter int COORD_WIDTH = 16,
  parameter int COLOR_WIDTH = 16
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   tri_valid,
  output logic                                   tri_ready,
  input  logic [COORD_WIDTH-1:0]                 tri_xmin,
  input  logic [COORD_WIDTH-1:0]                 tri_xmax,
  input  logic [COORD_WIDTH-1:0]                 tri_ymin,
  input  logic [COORD_WIDTH-1:0]                 tri_ymax,
  input  logic [2:0][2:0][COORD_WIDTH-1:0]       tri_bounds,
  input  logic [COLOR_WIDTH-1:0]                 tri_color,
  output logic                                   pix_valid,
  input  logic                                   pix_ready,
  output logic [COORD_WIDTH-1:0]                 pix_x,
  output logic [COORD_WIDTH-1:0]                 pix_y,
  output logic [2:0][2:0][COORD_WIDTH-1:0]       pix_bounds,
  output logic [COLOR_WIDTH-1:0]                 pix_color,
  output logic                                   pix_last,
  output logic                                   busy
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                 state, state_nxt;
  logic [COORD_WIDTH-1:0] xmin_q, xmax_q, ymax_q;
  logic                   accept, empty_box, xfer, at_xmax, at_end;

  assign accept    = tri_valid && tri_ready;
  assign empty_box = (tri_xmin > tri_xmax) || (tri_ymin > tri_ymax);
  assign xfer      = pix_valid && pix_ready;
  assign at_xmax   = (pix_x == xmax_q);
  assign at_end    = at_xmax && (pix_y == ymax_q);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept && !empty_box) state_nxt = SCAN;
      SCAN: if (xfer && at_end)       state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  // outputs decoded from registered state only
  always_comb begin
    tri_ready = (state == IDLE);
    pix_valid = (state == SCAN);
    busy      = (state == SCAN);
    pix_last  = (state == SCAN) && at_end;
  end

  // Equality-only termination: on the final pixel nothing is incremented, so
  // a box touching the top of the coordinate range never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_x      <= '0;
      pix_y      <= '0;
      pix_bounds <= '0;
      pix_color  <= '0;
      xmin_q     <= '0;
      xmax_q     <= '0;
      ymax_q     <= '0;
    end else if (accept) begin
      pix_x      <= tri_xmin;
      pix_y      <= tri_ymin;
      pix_bounds <= tri_bounds;
      pix_color  <= tri_color;
      xmin_q     <= tri_xmin;
      xmax_q     <= tri_xmax;
      ymax_q     <= tri_ymax;
    end else if (xfer && !at_end) begin
      if (!at_xmax) begin
        pix_x <= pix_x + 1'b1;
      end else begin
        pix_x <= xmin_q;
        pix_y <= pix_y + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_raster_scan.sv
// Randomized bench for raster_scan: expected pixel streams come from a nested
// loop over each bounding box, compared cycle by cycle under varied backpressure.
module tb_raster_scan;
  localparam int CW = 16;
  localparam int KW = 16;

  logic                         clk = 0;
  logic                         rst_n;
  logic                         tri_valid;
  logic                         tri_ready;
  logic [CW-1:0]                tri_xmin, tri_xmax, tri_ymin, tri_ymax;
  logic [2:0][2:0][CW-1:0]      tri_bounds;
  logic [KW-1:0]                tri_color;
  logic                         pix_valid;
  logic                         pix_ready;
  logic [CW-1:0]                pix_x, pix_y;
  logic [2:0][2:0][CW-1:0]      pix_bounds;
  logic [KW-1:0]                pix_color;
  logic                         pix_last;
  logic                         busy;

  raster_scan #(.COORD_WIDTH(CW), .COLOR_WIDTH(KW)) dut (
    .clk(clk), .rst_n(rst_n),
    .tri_valid(tri_valid), .tri_ready(tri_ready),
    .tri_xmin(tri_xmin), .tri_xmax(tri_xmax), .tri_ymin(tri_ymin), .tri_ymax(tri_ymax),
    .tri_bounds(tri_bounds), .tri_color(tri_color),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_bounds(pix_bounds), .pix_color(pix_color),
    .pix_last(pix_last), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {int x; int y; bit last;} pix_t;
  pix_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_outs();
    check("rst_pix_valid", pix_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_pix_last", pix_last, 0);
    check("rst_pix_xy", {pix_x, pix_y}, 0);
    check("rst_pix_bounds", pix_bounds, 0);
    check("rst_pix_color", pix_color, 0);
  endtask

  // mode: 0 = always ready, 1 = ready pattern 1,0,0,..., 2 = random ready
  // abort_after >= 0 pulses reset while that pixel index is being presented
  task automatic run_tri(input int xmin, input int xmax, input int ymin, input int ymax,
                         input logic [KW-1:0] color, input logic [2:0][2:0][CW-1:0] bnd,
                         input int mode, input int abort_after);
    pix_t e;
    int   n = 0, k = 0, budget;
    logic rdy;
    exp_q.delete();
    for (int y = ymin; y <= ymax; y++)
      for (int x = xmin; x <= xmax; x++)
        exp_q.push_back('{x, y, 1'b0});
    if (exp_q.size() > 0) exp_q[$].last = 1'b1;
    budget = exp_q.size() * 4 + 10;

    check("accept_tri_ready", tri_ready, 1);
    tri_valid  = 1;
    tri_xmin   = xmin[CW-1:0];
    tri_xmax   = xmax[CW-1:0];
    tri_ymin   = ymin[CW-1:0];
    tri_ymax   = ymax[CW-1:0];
    tri_color  = color;
    tri_bounds = bnd;
    @(negedge clk);
    tri_valid = 0;

    while (exp_q.size() > 0 && budget > 0) begin
      e = exp_q[0];
      if (n == abort_after) begin
        rst_n = 0;
        #1;
        check_reset_outs();
        exp_q.delete();
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        check("post_rst_tri_ready", tri_ready, 1);
        check("post_rst_pix_valid", pix_valid, 0);
        return;
      end
      check("pix_valid", pix_valid, 1);
      check("pix_x_y_last", {pix_x, pix_y, pix_last}, {e.x[CW-1:0], e.y[CW-1:0], e.last});
      check("pix_color", pix_color, color);
      check("pix_bounds", pix_bounds, bnd);
      check("busy_tri_ready", {busy, tri_ready}, 2'b10);
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (k % 3 == 0) : 1'($urandom_range(0, 1));
      pix_ready = rdy;
      k++;
      if (rdy) begin
        void'(exp_q.pop_front());
        n++;
      end
      @(negedge clk);
      budget--;
    end
    if (exp_q.size() > 0) check("timeout_pixels_left", exp_q.size(), 0);
    check("done_pix_valid", pix_valid, 0);
    check("done_tri_ready", tri_ready, 1);
    check("done_busy", busy, 0);
    pix_ready = 0;
  endtask

  initial begin
    logic [2:0][2:0][CW-1:0] bnd;
    int xmin, xmax, ymin, ymax;

    rst_n = 0; tri_valid = 0; pix_ready = 0;
    tri_xmin = 0; tri_xmax = 0; tri_ymin = 0; tri_ymax = 0;
    tri_bounds = '0; tri_color = 0;
    repeat (3) @(negedge clk);
    check_reset_outs();
    rst_n = 1;
    @(negedge clk);
    check("init_tri_ready", tri_ready, 1);
    check("init_pix_valid", pix_valid, 0);

    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        bnd[i][j] = CW'(i * 3 + j + 1);

    run_tri(2, 4, 10, 11, 16'h07E0, bnd, 0, -1);
    run_tri(2, 4, 10, 11, 16'h001F, bnd, 1, -1);
    run_tri(5, 4, 0, 0, 16'h1111, bnd, 0, -1);
    run_tri(3, 3, 9, 2, 16'h2222, bnd, 0, -1);
    run_tri(16'hFFFE, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hAAAA, bnd, 0, -1);
    run_tri(16'hFFFF, 16'hFFFF, 16'hFFFE, 16'hFFFF, 16'h5555, bnd, 2, -1);
    bnd = {9{16'h1234}};
    run_tri(7, 7, 7, 7, 16'hF800, bnd, 0, -1);
    run_tri(0, 3, 0, 3, 16'h0F0F, bnd, 0, 2);
    run_tri(20, 22, 30, 31, 16'h3333, bnd, 2, -1);

    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          bnd[i][j] = CW'($urandom);
      xmin = ($urandom_range(0, 3) == 0) ? 65535 - $urandom_range(0, 3) : $urandom_range(0, 2000);
      ymin = ($urandom_range(0, 3) == 0) ? 65535 - $urandom_range(0, 3) : $urandom_range(0, 2000);
      xmax = xmin + $urandom_range(0, 4);
      ymax = ymin + $urandom_range(0, 3);
      if (xmax > 65535) xmax = 65535;
      if (ymax > 65535) ymax = 65535;
      if ($urandom_range(0, 7) == 0 && xmin > 0) xmax = xmin - 1;
      run_tri(xmin, xmax, ymin, ymax, KW'($urandom), bnd, $urandom_range(0, 2), -1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
